i2c_master: RTL and testbench



---
 rtl/i2c_master_if.sv | 24 ++
 rtl/i2c_master.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_if.sv
// rtl/i2c_master_if.sv - Wishbone register port and open-drain SCL/SDA pin bundle for i2c_master
interface i2c_master_if;
  logic        I2CM_STB_I;
  logic        I2CM_WE_I;
  logic [5:0]  I2CM_ADR_I;
  logic [31:0] I2CM_DAT_I;
  logic        I2CM_ACK_O;
  logic [31:0] I2CM_DAT_O;
  logic        scl_in;
  logic        sda_in;
  logic        scl_oe;
  logic        sda_oe;
  logic        int_i2cm;

  modport slave (
    input  I2CM_STB_I, I2CM_WE_I, I2CM_ADR_I, I2CM_DAT_I, scl_in, sda_in,
    output I2CM_ACK_O, I2CM_DAT_O, scl_oe, sda_oe, int_i2cm
  );

  modport master (
    output I2CM_STB_I, I2CM_WE_I, I2CM_ADR_I, I2CM_DAT_I, scl_in, sda_in,
    input  I2CM_ACK_O, I2CM_DAT_O, scl_oe, sda_oe, int_i2cm
  );
endinterface

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - Wishbone I2C master byte engine (START / WRITE|READ+ACK / STOP)
// Optional clock stretching is built when I2CM_STRETCH_EN is defined.
module i2c_master #(
  parameter logic [15:0] DIV_RST = 16'd99
) (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  i2c_master_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [5:0] ADR_CMD  = 6'h00;
  localparam logic [5:0] ADR_STAT = 6'h04;
  localparam logic [5:0] ADR_DIV  = 6'h08;

  logic [2:0]  state_q, state_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        xfer_q, xfer_d;
  logic        rd_q, rd_d;
  logic        stop_q, stop_d;
  logic        nack_q, nack_d;
  logic        hold_q, hold_d;
  logic        rx_nack_q, rx_nack_d;
  logic        arb_lost_q, arb_lost_d;
  logic        done_q, done_d;
  logic        cmd_lost_q, cmd_lost_d;
  logic        irq_en_q, irq_en_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;

  logic        access;
  logic        cmd_wr;
  logic        stat_wr;
  logic        div_wr;
  logic        busy;
  logic        stall;
  logic        tick;
  logic        set_done;
  logic        set_arb;
  logic [31:0] wdat;
  logic        unused_dat;

  assign wdat    = bus.I2CM_DAT_I;
  assign access  = bus.I2CM_STB_I & ~ack_q;
  assign cmd_wr  = access & bus.I2CM_WE_I & (bus.I2CM_ADR_I == ADR_CMD);
  assign stat_wr = access & bus.I2CM_WE_I & (bus.I2CM_ADR_I == ADR_STAT);
  assign div_wr  = access & bus.I2CM_WE_I & (bus.I2CM_ADR_I == ADR_DIV);
  assign busy    = (state_q != ST_IDLE);
  assign unused_dat = ^wdat[31:17];

`ifdef I2CM_STRETCH_EN
  // A slave holding SCL low while we release it freezes the quarter timer.
  assign stall = busy & ~scl_oe_q & ~bus.scl_in;
`else
  logic unused_scl;
  assign unused_scl = bus.scl_in;
  assign stall      = 1'b0;
`endif

  assign tick = busy & ~stall & (cnt_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    xfer_d    = xfer_q;
    rd_d      = rd_q;
    stop_d    = stop_q;
    nack_d    = nack_q;
    hold_d    = hold_q;
    rx_nack_d = rx_nack_q;
    set_done  = 1'b0;
    set_arb   = 1'b0;

    if (busy && !stall) begin
      cnt_d = tick ? div_q : (cnt_q - 16'd1);
    end
    if (tick) begin
      quarter_d = quarter_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_wr && (wdat[11:8] != 4'd0)) begin
          tx_d      = wdat[7:0];
          stop_d    = wdat[9];
          xfer_d    = wdat[10] | wdat[11];
          rd_d      = wdat[11] & ~wdat[10];
          nack_d    = wdat[12];
          quarter_d = 2'd0;
          bit_cnt_d = 3'd7;
          cnt_d     = div_q;
          if (wdat[8]) begin
            state_d = ST_START;
          end else if (wdat[10] | wdat[11]) begin
            state_d = ST_BIT;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_START: begin
        if (tick) begin
          if (quarter_q == 2'd0 && !bus.sda_in) begin
            state_d = ST_IDLE;
            hold_d  = 1'b0;
            set_arb = 1'b1;
            set_done = 1'b1;
          end else if (quarter_q == 2'd3) begin
            hold_d = 1'b1;
            if (xfer_q) begin
              state_d = ST_BIT;
            end else if (stop_q) begin
              state_d = ST_STOP;
            end else begin
              state_d  = ST_IDLE;
              set_done = 1'b1;
            end
          end
        end
      end
      ST_BIT: begin
        if (tick) begin
          if (quarter_q == 2'd2) begin
            rx_sh_d = {rx_sh_q[6:0], bus.sda_in};
            if (!rd_q && tx_q[7] && !bus.sda_in) begin
              state_d  = ST_IDLE;
              hold_d   = 1'b0;
              set_arb  = 1'b1;
              set_done = 1'b1;
            end
          end else if (quarter_q == 2'd3) begin
            tx_d = {tx_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd0) begin
              state_d = ST_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          if (quarter_q == 2'd2) begin
            if (!rd_q) begin
              rx_nack_d = bus.sda_in;
            end
          end else if (quarter_q == 2'd3) begin
            if (rd_q) begin
              rx_byte_d = rx_sh_q;
            end
            if (stop_q) begin
              state_d = ST_STOP;
            end else begin
              state_d  = ST_IDLE;
              hold_d   = 1'b1;
              set_done = 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick && quarter_q == 2'd3) begin
          state_d  = ST_IDLE;
          hold_d   = 1'b0;
          set_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end

  // Pin drivers are registered from the next state so they change together with it.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        scl_oe_d = hold_d;
      end
      ST_START: begin
        scl_oe_d = quarter_d[1];
        sda_oe_d = (quarter_d != 2'd0);
      end
      ST_BIT: begin
        scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
        sda_oe_d = ~rd_d & ~tx_d[7];
      end
      ST_ACK: begin
        scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
        sda_oe_d = rd_d & ~nack_d;
      end
      ST_STOP: begin
        scl_oe_d = (quarter_d == 2'd0);
        sda_oe_d = (quarter_d < 2'd2);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    arb_lost_d = set_arb  | (arb_lost_q & ~(stat_wr & wdat[10]));
    done_d     = set_done | (done_q     & ~(stat_wr & wdat[11]));
    cmd_lost_d = (cmd_wr & busy) | (cmd_lost_q & ~(stat_wr & wdat[12]));
    irq_en_d   = stat_wr ? wdat[16] : irq_en_q;
    div_d      = (div_wr && !busy) ? wdat[15:0] : div_q;
    ack_d      = access;
    dat_d      = dat_q;
    if (access && !bus.I2CM_WE_I) begin
      case (bus.I2CM_ADR_I)
        ADR_CMD:  dat_d = 32'd0;
        ADR_STAT: dat_d = {15'd0, irq_en_q, 3'd0, cmd_lost_q, done_q, arb_lost_q,
                           rx_nack_q, busy, rx_byte_q};
        ADR_DIV:  dat_d = {16'd0, div_q};
        default:  dat_d = 32'hdeaddead;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= ST_IDLE;
      quarter_q  <= 2'd0;
      bit_cnt_q  <= 3'd0;
      cnt_q      <= 16'd0;
      div_q      <= DIV_RST;
      tx_q       <= 8'd0;
      rx_sh_q    <= 8'd0;
      rx_byte_q  <= 8'd0;
      xfer_q     <= 1'b0;
      rd_q       <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
      hold_q     <= 1'b0;
      rx_nack_q  <= 1'b0;
      arb_lost_q <= 1'b0;
      done_q     <= 1'b0;
      cmd_lost_q <= 1'b0;
      irq_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      quarter_q  <= quarter_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      xfer_q     <= xfer_d;
      rd_q       <= rd_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
      hold_q     <= hold_d;
      rx_nack_q  <= rx_nack_d;
      arb_lost_q <= arb_lost_d;
      done_q     <= done_d;
      cmd_lost_q <= cmd_lost_d;
      irq_en_q   <= irq_en_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign bus.I2CM_ACK_O = ack_q;
  assign bus.I2CM_DAT_O = dat_q;
  assign bus.scl_oe     = scl_oe_q;
  assign bus.sda_oe     = sda_oe_q;
  assign bus.int_i2cm   = done_q & irq_en_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - scoreboard bench for i2c_master with a bit-level I2C slave model
module tb_i2c_master;

  localparam int M_WRITE = 0;
  localparam int M_READ  = 1;
  localparam int M_ARB   = 2;

  logic clk;
  logic rst_n;
  logic stretch;
  logic slv_pull;

  i2c_master_if bus();

  assign bus.scl_in = ~bus.scl_oe & ~stretch;
  assign bus.sda_in = ~bus.sda_oe & ~slv_pull;

  i2c_master #(.DIV_RST(16'd99)) dut (
    .CLK_I  (clk),
    .RST_N_I(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  string       name_q[$];

  // slave model state
  int         k = 0;
  logic [7:0] cap = 8'd0;
  logic       ack_bit = 1'b1;
  int         slv_mode = M_WRITE;
  logic [7:0] rdata = 8'd0;
  int         slv_epoch = 0;
  int         seen_epoch = 0;
  logic       scl_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Read-data scoreboard: pops an expectation whenever the DUT acknowledges a read.
  initial begin
    logic [31:0] e;
    logic [31:0] m;
    string       n;
    forever begin
      @(negedge clk);
      if (bus.I2CM_ACK_O === 1'b1 && bus.I2CM_WE_I === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected actual=%h required=none", bus.I2CM_DAT_O);
        end else begin
          e = exp_q.pop_front();
          m = mask_q.pop_front();
          n = name_q.pop_front();
          if ((bus.I2CM_DAT_O & m) !== (e & m)) begin
            failures++;
            $display("FAIL %s actual=%h required=%h mask=%h", n, bus.I2CM_DAT_O, e, m);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (slv_epoch != seen_epoch) begin
        seen_epoch = slv_epoch;
        k        = 0;
        slv_pull = 1'b0;
        cap      = 8'd0;
        ack_bit  = 1'b1;
      end else if (bus.scl_in && !scl_prev) begin
        if (k < 8) cap = {cap[6:0], bus.sda_in};
        else if (k == 8) ack_bit = bus.sda_in;
        k++;
      end else if (!bus.scl_in && scl_prev) begin
        case (slv_mode)
          M_WRITE: slv_pull = (k == 8);
          M_READ:  slv_pull = (k < 8) ? ~rdata[7-k] : 1'b0;
          M_ARB:   slv_pull = (k == 2);
          default: slv_pull = 1'b0;
        endcase
      end
      scl_prev = bus.scl_in;
    end
  end

  task automatic slave_reset(input int mode, input logic [7:0] rd);
    slv_mode = mode;
    rdata    = rd;
    slv_epoch++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [5:0] adr, input logic [31:0] dat);
    bus.I2CM_STB_I = 1'b1;
    bus.I2CM_WE_I  = 1'b1;
    bus.I2CM_ADR_I = adr;
    bus.I2CM_DAT_I = dat;
    @(posedge clk);
    #1;
    bus.I2CM_STB_I = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_read(input logic [5:0] adr, input logic [31:0] req,
                         input logic [31:0] mask, input string name);
    exp_q.push_back(req);
    mask_q.push_back(mask);
    name_q.push_back(name);
    bus.I2CM_STB_I = 1'b1;
    bus.I2CM_WE_I  = 1'b0;
    bus.I2CM_ADR_I = adr;
    bus.I2CM_DAT_I = 32'd0;
    @(posedge clk);
    #1;
    bus.I2CM_STB_I = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // n = clock edges after the CMD accept edge at which int_i2cm is first seen.
  task automatic wait_int(input int limit, output int n);
    n = 1;
    while (bus.int_i2cm !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int w;
    int bad;
    rst_n          = 1'b0;
    stretch        = 1'b0;
    slv_pull       = 1'b0;
    bus.I2CM_STB_I = 1'b0;
    bus.I2CM_WE_I  = 1'b0;
    bus.I2CM_ADR_I = 6'd0;
    bus.I2CM_DAT_I = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oe", {31'd0, bus.scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("rst_ack", {31'd0, bus.I2CM_ACK_O}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wb_read(6'h04, 32'h0, 32'hffff_ffff, "rst_stat");
    wb_read(6'h08, 32'd99, 32'hffff_ffff, "rst_div");
    wb_read(6'h3c, 32'hdeaddead, 32'hffff_ffff, "unmapped");

    // write 0x50 with START and STOP at Q=0
    wb_write(6'h08, 32'd0);
    wb_write(6'h04, 32'h0001_0000);
    slave_reset(M_WRITE, 8'h00);
    wb_write(6'h00, 32'h0000_0750);
    wait_int(200, n);
    chk("wr_done_cycles", 32'(n), 32'd44);
    chk("wr_sda_bits", {24'd0, cap}, 32'h50);
    chk("wr_scl_rises", 32'(k), 32'd10);
    wb_read(6'h04, 32'h0001_0800, 32'h0001_1f00, "wr_stat");
    wb_write(6'h04, 32'h0001_0800);
    chk("done_clear_int", {31'd0, bus.int_i2cm}, 32'd0);

    // read 0xA5 with NACK and STOP
    slave_reset(M_READ, 8'ha5);
    wb_write(6'h00, 32'h0000_1a00);
    wait_int(200, n);
    chk("rd_done_cycles", 32'(n), 32'd40);
    chk("rd_ack_slot_sda", {31'd0, ack_bit}, 32'd1);
    chk("rd_int", {31'd0, bus.int_i2cm}, 32'd1);
    wb_read(6'h04, 32'h0001_08a5, 32'h0001_1fff, "rd_stat");
    wb_write(6'h04, 32'h0001_0800);

    // second CMD while busy is dropped
    wb_write(6'h08, 32'd3);
    slave_reset(M_WRITE, 8'h00);
    wb_write(6'h00, 32'h0000_0750);
    wb_write(6'h00, 32'h0000_0750);
    wb_read(6'h04, 32'h0000_1100, 32'h0000_1100, "busy_lost_stat");
    wb_write(6'h04, 32'h0001_1000);
    wb_read(6'h04, 32'h0000_0000, 32'h0000_1000, "lost_cleared");
    wait_int(600, n);
    chk("busy_done", {31'd0, bus.int_i2cm}, 32'd1);
    repeat (60) @(posedge clk);
    #1;
    chk("busy_one_byte", 32'(k), 32'd10);
    chk("busy_byte", {24'd0, cap}, 32'h50);
    wb_write(6'h04, 32'h0001_0800);

    // arbitration lost on the third bit of 0xFF
    wb_write(6'h08, 32'd0);
    slave_reset(M_ARB, 8'h00);
    wb_write(6'h00, 32'h0000_07ff);
    w = 0;
    while (k < 3 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("arb_reached_bit2", {31'd0, (k >= 3)}, 32'd1);
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    chk("arb_oe_released", 32'(bad), 32'd0);
    chk("arb_int", {31'd0, bus.int_i2cm}, 32'd1);
    wb_read(6'h04, 32'h0000_0c00, 32'h0000_1d00, "arb_stat");
    slave_reset(M_WRITE, 8'h00);
    wb_write(6'h04, 32'h0001_0c00);

`ifdef I2CM_STRETCH_EN
    slave_reset(M_WRITE, 8'h00);
    wb_write(6'h00, 32'h0000_0750);
    fork
      begin
        w = 0;
        while (bus.scl_oe !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        while (bus.scl_oe !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        stretch = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        stretch = 1'b0;
      end
      wait_int(300, n);
    join
    chk("stretch_done_cycles", 32'(n), 32'd64);
    wb_write(6'h04, 32'h0001_0800);
`endif

    // asynchronous reset in the middle of a byte
    wb_write(6'h08, 32'd3);
    slave_reset(M_WRITE, 8'h00);
    wb_write(6'h00, 32'h0000_07ff);
    repeat (22) @(posedge clk);
    #1;
    w = 0;
    while (bus.scl_oe !== 1'b1 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("midrst_driving", {31'd0, bus.scl_oe}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_scl_oe", {31'd0, bus.scl_oe}, 32'd0);
    chk("midrst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slave_reset(M_WRITE, 8'h00);
    wb_read(6'h04, 32'h0, 32'hffff_ffff, "midrst_stat");
    wb_read(6'h08, 32'd99, 32'hffff_ffff, "midrst_div");
    chk("midrst_int", {31'd0, bus.int_i2cm}, 32'd0);

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
